// File: rtl/fp_adder_sequencer.sv
// Round-robin front end that lets NUM_REQ parallel-word requesters share one
// bit-serial FP adder: load operands LSB first, wait for the result, read it back.
module fp_adder_sequencer #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    input  logic [NUM_REQ*32-1:0]  req_c,
    input  logic [NUM_REQ*32-1:0]  req_d,
    input  logic [NUM_REQ*8-1:0]   req_setup,
    output logic                   resp_valid,
    output logic [2:0]             resp_id,
    output logic [31:0]            resp_data,
    output logic                   resp_error,
    output logic                   busy,
    output logic                   adder_serial1,
    output logic                   adder_serial2,
    output logic                   adder_serial3,
    output logic                   adder_serial4,
    output logic                   adder_wr,
    output logic                   adder_setup_serial,
    input  logic                   adder_input_rdy,
    input  logic                   adder_output_rdy,
    output logic                   adder_output_read,
    input  logic                   adder_serial_out
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_GAP, S_READ, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         id_q, id_d;
    logic [31:0]        a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [7:0]         setup_q, setup_d;
    logic [31:0]        result_q, result_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [2:0]         resp_id_q, resp_id_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               resp_error_q, resp_error_d;

    // Requester slots padded to 8 so a 3-bit index addresses them exactly.
    logic [7:0]  valid_ext;
    logic [31:0] a_arr [8];
    logic [31:0] b_arr [8];
    logic [31:0] c_arr [8];
    logic [31:0] d_arr [8];
    logic [7:0]  setup_arr [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_used
                assign valid_ext[gi] = req_valid[gi];
                assign a_arr[gi]     = req_a[gi*32 +: 32];
                assign b_arr[gi]     = req_b[gi*32 +: 32];
                assign c_arr[gi]     = req_c[gi*32 +: 32];
                assign d_arr[gi]     = req_d[gi*32 +: 32];
                assign setup_arr[gi] = req_setup[gi*8 +: 8];
            end else begin : g_unused
                assign valid_ext[gi] = 1'b0;
                assign a_arr[gi]     = '0;
                assign b_arr[gi]     = '0;
                assign c_arr[gi]     = '0;
                assign d_arr[gi]     = '0;
                assign setup_arr[gi] = '0;
            end
        end
    endgenerate

    logic       grant_found;
    logic [2:0] grant_idx;

    // First valid requester strictly after the last one served.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_found && valid_ext[3'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(cand);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ptr_q        <= 3'(NUM_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            setup_q      <= '0;
            result_q     <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            setup_q      <= setup_d;
            result_q     <= result_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        setup_d      = setup_q;
        result_d     = result_q;
        req_ready_d  = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        case (state_q)
            S_IDLE: begin
                if (adder_input_rdy && grant_found) begin
                    a_d     = a_arr[grant_idx];
                    b_d     = b_arr[grant_idx];
                    c_d     = c_arr[grant_idx];
                    d_d     = d_arr[grant_idx];
                    setup_d = setup_arr[grant_idx];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        req_ready_d[k] = (3'(k) == grant_idx);
                    end
                end
            end
            S_LOAD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd31) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (adder_output_rdy) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    cnt_d        = '0;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_data_d  = '0;
                    resp_error_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_GAP: begin
                cnt_d   = '0;
                state_d = S_READ;
            end
            S_READ: begin
                // Result arrives LSB first, so shift in from the top.
                result_d = {adder_serial_out, result_q[31:1]};
                cnt_d    = cnt_q + 8'd1;
                if (cnt_q == 8'd31) begin
                    cnt_d        = '0;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_data_d  = result_d;
                    resp_error_d = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        adder_wr           = 1'b0;
        adder_serial1      = 1'b0;
        adder_serial2      = 1'b0;
        adder_serial3      = 1'b0;
        adder_serial4      = 1'b0;
        adder_setup_serial = 1'b0;
        adder_output_read  = 1'b0;
        busy               = (state_q != S_IDLE);
        case (state_q)
            S_LOAD: begin
                adder_wr      = 1'b1;
                adder_serial1 = d_q[cnt_q[4:0]];
                adder_serial2 = c_q[cnt_q[4:0]];
                adder_serial3 = b_q[cnt_q[4:0]];
                adder_serial4 = a_q[cnt_q[4:0]];
                // Setup occupies the last eight load cycles only.
                if (cnt_q >= 8'd24) adder_setup_serial = setup_q[cnt_q[2:0]];
            end
            S_GAP, S_READ: begin
                adder_output_read = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_error = resp_error_q;

endmodule

// File: tb/tb_fp_adder_sequencer.sv
// Bench for fp_adder_sequencer: serial adder stub, round-robin/response
// scoreboard, directed vectors and corner sequences, then random traffic.
module tb_fp_adder_sequencer;
    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 16;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a, req_b, req_c, req_d;
    logic [NUM_REQ*8-1:0]  req_setup;
    logic                  resp_valid;
    logic [2:0]            resp_id;
    logic [31:0]           resp_data;
    logic                  resp_error;
    logic                  busy;
    logic                  adder_serial1, adder_serial2, adder_serial3, adder_serial4;
    logic                  adder_wr, adder_setup_serial;
    logic                  adder_input_rdy;
    logic                  adder_output_rdy;
    logic                  adder_output_read;
    logic                  adder_serial_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    fp_adder_sequencer #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .req_setup(req_setup),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_error(resp_error), .busy(busy),
        .adder_serial1(adder_serial1), .adder_serial2(adder_serial2),
        .adder_serial3(adder_serial3), .adder_serial4(adder_serial4),
        .adder_wr(adder_wr), .adder_setup_serial(adder_setup_serial),
        .adder_input_rdy(adder_input_rdy), .adder_output_rdy(adder_output_rdy),
        .adder_output_read(adder_output_read), .adder_serial_out(adder_serial_out)
    );

    // Stand-in adder arithmetic: every operand position and setup bit matters.
    function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d,
                                             input logic [7:0] s);
        return (a + 32'd3 * b + 32'd5 * c + 32'd7 * d) ^ {s, s, s, s} ^ 32'h5a5a0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- serial adder stub ----------------
    int          ld_cnt, rd_cnt, stub_dly, last_ld_len;
    int          setup_viol = 0;
    logic [31:0] sh_a, sh_b, sh_c, sh_d, out_sh;
    logic [7:0]  sh_s;
    logic        stub_pend;
    bit          stub_stuck = 1'b0;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ld_cnt    <= 0;
            rd_cnt    <= 0;
            stub_pend <= 1'b0;
            stub_dly  <= 0;
            out_sh    <= '0;
        end else begin
            if (stub_pend && stub_dly != 0) stub_dly <= stub_dly - 1;
            if (adder_output_read) begin
                stub_pend <= 1'b0;
                rd_cnt    <= rd_cnt + 1;
                if (rd_cnt >= 1) out_sh <= {1'b0, out_sh[31:1]};
            end
            if (adder_wr) begin
                stub_pend <= 1'b0;
                ld_cnt    <= ld_cnt + 1;
                sh_a      <= {adder_serial4, sh_a[31:1]};
                sh_b      <= {adder_serial3, sh_b[31:1]};
                sh_c      <= {adder_serial2, sh_c[31:1]};
                sh_d      <= {adder_serial1, sh_d[31:1]};
                if (ld_cnt >= 24) sh_s <= {adder_setup_serial, sh_s[7:1]};
                else if (adder_setup_serial) setup_viol <= setup_viol + 1;
            end else begin
                if (adder_setup_serial) setup_viol <= setup_viol + 1;
                if (ld_cnt != 0) begin
                    last_ld_len <= ld_cnt;
                    ld_cnt      <= 0;
                    out_sh      <= adder_fn(sh_a, sh_b, sh_c, sh_d, sh_s);
                    stub_pend   <= 1'b1;
                    stub_dly    <= int'($urandom_range(0, 8));
                    rd_cnt      <= 0;
                end
            end
        end
    end

    assign adder_output_rdy = stub_pend && (stub_dly == 0) && !stub_stuck;
    assign adder_serial_out = (rd_cnt >= 1 && rd_cnt <= 32) ? out_sh[0] : 1'b0;

    // ---------------- scoreboard / arbitration model ----------------
    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t                  exp_q[$];
    int                    model_ptr = NUM_REQ - 1;
    int                    mon_g, mon_c;
    bit                    outstanding = 1'b0;
    logic                  prev_rv = 1'b0;
    logic [31:0]           prev_data;
    logic [2:0]            prev_id;
    logic [NUM_REQ-1:0]    vsnap;
    logic [NUM_REQ*32-1:0] asnap, bsnap, csnap, dsnap;
    logic [NUM_REQ*8-1:0]  ssnap;
    exp_t                  mon_e;

    always @(posedge clk_in) begin
        vsnap <= req_valid;
        asnap <= req_a;
        bsnap <= req_b;
        csnap <= req_c;
        dsnap <= req_d;
        ssnap <= req_setup;
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            exp_q.delete();
            outstanding = 1'b0;
            model_ptr   = NUM_REQ - 1;
            prev_rv     = 1'b0;
        end else begin
            if (prev_rv) begin
                check("resp_valid_pulse", 32'(resp_valid), 32'd0);
                check("resp_data_hold", resp_data, prev_data);
                check("resp_id_hold", 32'(resp_id), 32'(prev_id));
            end
            if (req_ready != '0) begin
                mon_g = -1;
                for (int off = 1; off <= NUM_REQ; off++) begin
                    mon_c = (model_ptr + off) % NUM_REQ;
                    if (mon_g < 0 && vsnap[mon_c]) mon_g = mon_c;
                end
                if (mon_g < 0) begin
                    fail_now("grant_without_valid", $sformatf("req_ready=%b with no valid request", req_ready));
                end else begin
                    check("grant_vector", 32'(req_ready), 32'(1 << mon_g));
                    check("ready_once_per_job", 32'(outstanding), 32'd0);
                    mon_e.id   = mon_g;
                    mon_e.err  = stub_stuck;
                    mon_e.data = stub_stuck ? 32'd0 :
                                 adder_fn(asnap[mon_g*32 +: 32], bsnap[mon_g*32 +: 32],
                                          csnap[mon_g*32 +: 32], dsnap[mon_g*32 +: 32],
                                          ssnap[mon_g*8 +: 8]);
                    exp_q.push_back(mon_e);
                    model_ptr   = mon_g;
                    outstanding = 1'b1;
                end
            end
            if (resp_valid) begin
                $display("txn: resp id=%0d data=0x%08h err=%0d", resp_id, resp_data, resp_error);
                if (exp_q.size() == 0) begin
                    fail_now("resp_unexpected", $sformatf("got resp id=%0d, required no response", resp_id));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_id", 32'(resp_id), 32'(mon_e.id));
                    check("resp_data", resp_data, mon_e.data);
                    check("resp_error", 32'(resp_error), 32'(mon_e.err));
                    check("adder_wr_cycles", 32'(last_ld_len), 32'd32);
                    check("setup_outside_window", 32'(setup_viol), 32'd0);
                end
                outstanding = 1'b0;
            end
            prev_rv   = resp_valid;
            prev_data = resp_data;
            prev_id   = resp_id;
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        int          k;
        logic [31:0] a, b, c, d;
        logic [7:0]  s;
        logic [31:0] exp;
    } vec_t;

    task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [7:0] s);
        req_a[k*32 +: 32] = a;
        req_b[k*32 +: 32] = b;
        req_c[k*32 +: 32] = c;
        req_d[k*32 +: 32] = d;
        req_setup[k*8 +: 8] = s;
    endtask

    task automatic set_rand(input int k);
        set_ops(k, $urandom(), $urandom(), $urandom(), $urandom(), 8'($urandom()));
    endtask

    task automatic wait_ready(input int k, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk_in);
            if (req_ready[k]) ok = 1'b1;
        end
        if (!ok) fail_now("ready_wait", $sformatf("req %0d got no req_ready, required within 50 cycles", k));
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk_in);
            if (resp_valid) ok = 1'b1;
        end
        if (!ok) fail_now("resp_wait", "no resp_valid, required within 400 cycles");
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 600 && !done; n++) begin
            @(negedge clk_in);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) fail_now("drain", "responses still outstanding after 600 cycles");
    endtask

    task automatic single_job(input vec_t v);
        bit ok;
        set_ops(v.k, v.a, v.b, v.c, v.d, v.s);
        req_valid[v.k] = 1'b1;
        wait_ready(v.k, ok);
        req_valid[v.k] = 1'b0;
        if (ok) begin
            wait_resp(ok);
            if (ok) begin
                check("vec_data", resp_data, v.exp);
                check("vec_id", 32'(resp_id), 32'(v.k));
                check("vec_error", 32'(resp_error), 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    localparam logic [31:0] ONE = 32'h3f800000;

    vec_t tbl[5];
    int   order[$];
    int   exp_order[3] = '{0, 1, 0};
    int   wr_seen, wait_cnt, grants;
    bit   ok, got, seen_rv;

    initial begin
        tbl[0] = '{k: 0, a: ONE, b: ONE, c: ONE, d: ONE, s: 8'h1E, exp: '0};
        tbl[1] = '{k: 1, a: ONE, b: ONE, c: ONE, d: ONE, s: 8'h18, exp: '0};
        tbl[2] = '{k: 0, a: 32'h00000001, b: 32'h80000000, c: 32'h12345678, d: 32'hdeadbeef, s: 8'h81, exp: '0};
        tbl[3] = '{k: 1, a: 32'hffffffff, b: 32'hffffffff, c: 32'hffffffff, d: 32'hffffffff, s: 8'hff, exp: '0};
        tbl[4] = '{k: 0, a: 32'h0, b: 32'h0, c: 32'h0, d: 32'h0, s: 8'h00, exp: '0};
        foreach (tbl[i]) tbl[i].exp = adder_fn(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].s);

        rst_in          = 1'b0;
        req_valid       = '0;
        req_a           = '0;
        req_b           = '0;
        req_c           = '0;
        req_d           = '0;
        req_setup       = '0;
        adder_input_rdy = 1'b1;
        repeat (3) @(negedge clk_in);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_id", 32'(resp_id), 32'd0);
        check("reset_resp_data", resp_data, 32'd0);
        check("reset_resp_error", 32'(resp_error), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_adder_lines", 32'({adder_serial1, adder_serial2, adder_serial3, adder_serial4,
                                        adder_setup_serial, adder_wr, adder_output_read}), 32'd0);
        rst_in = 1'b1;

        // Both requesters valid straight after reset, held for three jobs.
        set_ops(0, ONE, ONE, ONE, ONE, 8'h1E);
        set_ops(1, ONE, ONE, ONE, ONE, 8'h18);
        @(negedge clk_in);
        req_valid = '1;
        order.delete();
        for (int n = 0; n < 1000 && order.size() < 3; n++) begin
            @(negedge clk_in);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_ready[k]) begin
                    order.push_back(k);
                    set_rand(k);
                end
            end
        end
        req_valid = '0;
        drain();
        if (order.size() != 3) begin
            fail_now("rr_grant_count", $sformatf("got %0d grants, required 3", order.size()));
        end else begin
            for (int i = 0; i < 3; i++) check($sformatf("rr_order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));
        end

        foreach (tbl[i]) single_job(tbl[i]);

        // Adder never signals ready: error response after TIMEOUT wait cycles.
        stub_stuck = 1'b1;
        set_ops(1, $urandom(), $urandom(), $urandom(), $urandom(), 8'h5c);
        req_valid[1] = 1'b1;
        wait_ready(1, ok);
        req_valid[1] = 1'b0;
        wait_cnt = 0;
        got      = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk_in);
            if (resp_valid) got = 1'b1;
            else if (busy && !adder_wr && !adder_output_read) wait_cnt++;
        end
        check("timeout_resp_seen", 32'(got), 32'd1);
        check("timeout_wait_cycles", 32'(wait_cnt), 32'(TIMEOUT));
        check("timeout_error", 32'(resp_error), 32'd1);
        check("timeout_data", resp_data, 32'd0);
        check("timeout_id", 32'(resp_id), 32'd1);
        check("timeout_back_idle", 32'(busy), 32'd0);
        stub_stuck = 1'b0;
        drain();

        // Reset in the middle of the operand load.
        set_ops(0, ONE, ONE, ONE, ONE, 8'h1E);
        req_valid[0] = 1'b1;
        wait_ready(0, ok);
        req_valid[0] = 1'b0;
        wr_seen = adder_wr ? 1 : 0;
        for (int n = 0; n < 40 && wr_seen < 11; n++) begin
            @(negedge clk_in);
            if (adder_wr) wr_seen++;
        end
        check("load_bits_before_reset", 32'(wr_seen), 32'd11);
        rst_in = 1'b0;
        #1;
        check("reset_mid_load_wr", 32'(adder_wr), 32'd0);
        check("reset_mid_load_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_in  = 1'b1;
        seen_rv = 1'b0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk_in);
            if (resp_valid) seen_rv = 1'b1;
        end
        check("no_resp_after_abort", 32'(seen_rv), 32'd0);
        single_job(tbl[0]);

        // Adder not ready for input: no grant until it is.
        adder_input_rdy = 1'b0;
        set_ops(0, ONE, 32'h40000000, ONE, 32'h40400000, 8'h3c);
        req_valid[0] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_in);
            if (req_ready != '0 || busy) got = 1'b1;
        end
        check("no_grant_input_not_rdy", 32'(got), 32'd0);
        adder_input_rdy = 1'b1;
        @(negedge clk_in);
        check("grant_first_rdy_cycle", 32'(req_ready), 32'd1);
        req_valid[0] = 1'b0;
        drain();

        // Random traffic from both requesters, checked by the scoreboard.
        grants = 0;
        for (int cyc = 0; cyc < 20000 && grants < 40; cyc++) begin
            @(negedge clk_in);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    grants++;
                    if ($urandom_range(0, 1) == 1) set_rand(k);
                    else req_valid[k] = 1'b0;
                end else if (!req_valid[k] && $urandom_range(0, 99) < 8) begin
                    set_rand(k);
                    req_valid[k] = 1'b1;
                end
            end
        end
        req_valid = '0;
        check("random_grants_reached", 32'(grants >= 40), 32'd1);
        drain();
        check("setup_outside_window_final", 32'(setup_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2000000, required completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
